// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage with PC, word-addressed instruction memory and the
// IF/ID pipeline register. Handles stall, branch redirect and halt.
module pipe_fetch_stage #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n, instr_pc_n;
  logic [DATA_W-1:0]   instr_n;
  logic                valid_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   fetch_word;
  logic [5:0]          opcode;

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  // Combinational read at the current PC (sees the pre-write word this cycle).
  assign fetch_word = mem[pc];
  assign opcode     = fetch_word[DATA_W-1 -: 6];
  assign halted     = (state == HALT);

  // State, PC and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= PC_INIT;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
    end
  end

  // Next-state and IF/ID update: redirect beats stall beats normal fetch.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    unique case (state)
      RUN: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          instr_n = '0;
          valid_n = 1'b0;
        end else if (!stall) begin
          instr_n    = fetch_word;
          instr_pc_n = pc;
          valid_n    = 1'b1;
          if (opcode == HALT_OP) state_n = HALT;
          else                   pc_n    = pc + 1'b1;
        end
      end
      HALT: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          instr_n = '0;
          valid_n = 1'b0;
          state_n = RUN;
        end else if (!stall) begin
          instr_n = '0;
          valid_n = 1'b0;
        end
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Self-checking bench for pipe_fetch_stage: directed scenarios followed by
// randomized stall/redirect/write traffic, all compared against a
// cycle-level behavioural model.
module tb_pipe_fetch_stage;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [DW-1:0] imem_wdata = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halted;

  pipe_fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .HALT_OP(6'h3F)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc(pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_pc, m_ipc;
  logic [DW-1:0] m_instr;
  logic          m_valid, m_halt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_instr = '0; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       64'(pc),          64'(m_pc));
    check({tag, ".instr"},    64'(instr),       64'(m_instr));
    check({tag, ".instr_pc"}, 64'(instr_pc),    64'(m_ipc));
    check({tag, ".valid"},    64'(instr_valid), 64'(m_valid));
    check({tag, ".halted"},   64'(halted),      64'(m_halt));
  endtask

  // Apply inputs, advance one clock edge, update the model, compare.
  task automatic tick(input string tag, input logic s, input logic r, input int rpc,
                      input logic we, input int wa, input logic [DW-1:0] wd);
    logic [DW-1:0] w;
    stall = s; redirect = r; redirect_pc = AW'(rpc);
    imem_we = we; imem_waddr = AW'(wa); imem_wdata = wd;
    @(posedge clk);
    #1;
    w = m_mem[m_pc];
    if (r) begin
      m_pc = rpc; m_instr = '0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (!s) begin
      if (m_halt) begin
        m_instr = '0; m_valid = 1'b0;
      end else begin
        m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
        if (w[31:26] == 6'h3F) m_halt = 1'b1;
        else m_pc = (m_pc + 1) % DEPTH;
      end
    end
    if (we) m_mem[wa] = wd;
    check_all(tag);
  endtask

  task automatic step(input string tag);
    tick(tag, 1'b0, 1'b0, 0, 1'b0, 0, '0);
  endtask

  task automatic jump(input string tag, input int target);
    tick(tag, 1'b0, 1'b1, target, 1'b0, 0, '0);
  endtask

  initial begin
    logic [DW-1:0] w;
    model_reset();
    #1;
    check_all("reset");

    // Load memory while reset is held; no HALT opcodes except where placed.
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h3F) w[31] = 1'b0;
      if (i == 0) w = 32'h11;
      if (i == 1) w = 32'h22;
      if (i == 2) w = 32'h33;
      if (i == 3) w = 32'h44;
      if (i == 5) w = 32'hFC00_0000;
      if (i == 10) w = 32'hAA;
      imem_we = 1'b1; imem_waddr = AW'(i); imem_wdata = w;
      m_mem[i] = w;
      @(posedge clk);
      #1;
    end
    imem_we = 1'b0;
    check_all("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch
    for (int i = 0; i < 4; i++) step("seq");
    check("seq.instr4", 64'(instr), 64'h44);
    check("seq.pc4", 64'(pc), 64'd4);

    // Stall holding instr=22
    jump("st_redir", 0);
    step("st_a");
    step("st_b");
    check("st.instr22", 64'(instr), 64'h22);
    for (int i = 0; i < 3; i++) begin
      tick("stall", 1'b1, 1'b0, 0, 1'b0, 0, '0);
      check("stall.instr", 64'(instr), 64'h22);
      check("stall.pc", 64'(pc), 64'd2);
    end
    step("st_release");
    check("st.instr33", 64'(instr), 64'h33);

    // Redirect together with stall
    tick("redir_stall", 1'b1, 1'b1, 10, 1'b0, 0, '0);
    check("redir.valid", 64'(instr_valid), 64'd0);
    check("redir.pc", 64'(pc), 64'd10);
    step("redir_tgt");
    check("redir.instrAA", 64'(instr), 64'hAA);
    check("redir.ipc", 64'(instr_pc), 64'd10);

    // Halt and resume
    jump("halt_go", 5);
    step("halt_issue");
    check("halt.issue_valid", 64'(instr_valid), 64'd1);
    check("halt.issue_instr", 64'(instr), 64'hFC00_0000);
    for (int i = 0; i < 4; i++) step("halted");
    tick("halt_stall", 1'b1, 1'b0, 0, 1'b0, 0, '0);
    check("halt.pc", 64'(pc), 64'd5);
    check("halt.flag", 64'(halted), 64'd1);
    jump("halt_resume", 0);
    check("resume.halted", 64'(halted), 64'd0);
    step("resume_first");
    check("resume.instr11", 64'(instr), 64'h11);

    // Wrap-around
    jump("wrap_go", 63);
    step("wrap63");
    check("wrap.ipc63", 64'(instr_pc), 64'd63);
    step("wrap0");
    check("wrap.ipc0", 64'(instr_pc), 64'd0);
    check("wrap.valid", 64'(instr_valid), 64'd1);

    // Asynchronous reset mid-cycle while halted
    jump("ar_go", 5);
    step("ar_issue");
    step("ar_halted");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Write hazard on the word being fetched (pc=0)
    tick("hazard", 1'b0, 1'b0, 0, 1'b1, 0, 32'h55);
    check("hazard.old", 64'(instr), 64'h11);
    jump("hazard_redir", 0);
    step("hazard_new");
    check("hazard.new", 64'(instr), 64'h55);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic s, r, we;
      int rpc, wa;
      s   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 9) == 0);
      rpc = $urandom_range(0, DEPTH - 1);
      we  = ($urandom_range(0, 4) == 0);
      wa  = ($urandom_range(0, 1) == 0) ? m_pc : $urandom_range(0, DEPTH - 1);
      w   = $urandom;
      if ($urandom_range(0, 7) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31] = 1'b0;
      tick("rand", s, r, rpc, we, wa, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
